sweep_ctrl: RTL and testbench

- Command sequencer that sits directly upstream of the 6-bit up/down counter.
- It drives the counter's LOAD/DATA/COUNT_UP inputs and reads COUNT back, so the counter performs a bounded triangle sweep between LO and HI for N half-sweeps, then freezes.
- Accepts one command at a time over a valid/ready handshake and reports completion or error.

---
 rtl/sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: command sequencer for a 6-bit up/down counter.
// It drives the counter's LOAD/DATA/COUNT_UP and reads COUNT back, producing a
// bounded triangle sweep between LO and HI for N half-sweeps, then freezes.
// Optional feature: define SWEEP_CTRL_CYCLE_COUNT_EN to add the RUN_CYCLES output.
module sweep_ctrl #(
    parameter int WIDTH = 6,
    parameter int NW    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [WIDTH-1:0] CMD_LO,
    input  logic [WIDTH-1:0] CMD_HI,
    input  logic [WIDTH-1:0] CMD_START,
    input  logic             CMD_UP,
    input  logic [NW-1:0]    CMD_N,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] COUNT,
    output logic             LOAD,
    output logic [WIDTH-1:0] DATA,
    output logic             COUNT_UP,
    output logic             BUSY,
    output logic             DONE,
`ifdef SWEEP_CTRL_CYCLE_COUNT_EN
    output logic [15:0]      RUN_CYCLES,
`endif
    output logic             ERR
);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             up_q, up_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] park_q, park_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    hc_q, hc_d;

    logic [WIDTH-1:0] span;
    logic             cmd_ok;
    logic [NW-1:0]    hc_inc;
    logic [WIDTH-1:0] stop_val;

    // Command validity: START strictly inside (LO, HI), span of at least 2, N non-zero.
    always_comb begin
        span   = CMD_HI - CMD_LO;
        cmd_ok = (CMD_LO < CMD_START) && (CMD_START < CMD_HI) &&
                 (span >= TWO) && (CMD_N != '0);
    end

    // Next-state and registered-output logic for the sweep sequencer.
    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        data_d   = data_q;
        up_d     = up_q;
        dir_d    = dir_q;
        park_d   = park_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        n_d      = n_q;
        hc_d     = hc_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        hc_inc   = hc_q + 1'b1;
        stop_val = up_q ? (COUNT + ONE) : (COUNT - ONE);

        case (state_q)
            S_IDLE: begin
                load_d = 1'b1;
                data_d = park_q;
                if (CMD_VALID) begin
                    if (cmd_ok) begin
                        lo_d    = CMD_LO;
                        hi_d    = CMD_HI;
                        n_d     = CMD_N;
                        dir_d   = CMD_UP;
                        data_d  = CMD_START;
                        hc_d    = '0;
                        state_d = S_PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRIME: begin
                load_d  = 1'b0;
                up_d    = dir_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ABORT) begin
                    load_d  = 1'b1;
                    data_d  = stop_val;
                    park_d  = stop_val;
                    state_d = S_IDLE;
                end else if (up_q && (COUNT == hi_q - ONE)) begin
                    hc_d = hc_inc;
                    if (hc_inc == n_q) begin
                        load_d  = 1'b1;
                        data_d  = hi_q;
                        park_d  = hi_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        up_d = 1'b0;
                    end
                end else if (!up_q && (COUNT == lo_q + ONE)) begin
                    hc_d = hc_inc;
                    if (hc_inc == n_q) begin
                        load_d  = 1'b1;
                        data_d  = lo_q;
                        park_d  = lo_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        up_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            load_q  <= 1'b1;
            data_q  <= '0;
            up_q    <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            park_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            data_q  <= data_d;
            up_q    <= up_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
            park_q  <= park_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            hc_q    <= hc_d;
        end
    end

`ifdef SWEEP_CTRL_CYCLE_COUNT_EN
    logic [15:0] rc_q;

    // Active-cycle counter; the PRIME cycle is included so a full sweep
    // reports the whole time the controller was busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rc_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (CMD_VALID && cmd_ok) rc_q <= '0;
        end else if (rc_q != '1) begin
            rc_q <= rc_q + 16'd1;
        end
    end

    assign RUN_CYCLES = rc_q;
`endif

    assign CMD_READY = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign LOAD      = load_q;
    assign DATA      = data_q;
    assign COUNT_UP  = up_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Testbench for sweep_ctrl: table-driven commands, hand-written corner
// sequences and randomized commands checked against a triangle-sweep model.
module tb_sweep_ctrl;

    localparam int W  = 6;
    localparam int NW = 4;

    logic          CLK = 1'b0;
    logic          RESET, CMD_VALID, CMD_READY, CMD_UP, ABORT;
    logic          LOAD, COUNT_UP, BUSY, DONE, ERR;
    logic [W-1:0]  CMD_LO, CMD_HI, CMD_START, COUNT, DATA;
    logic [NW-1:0] CMD_N;
`ifdef SWEEP_CTRL_CYCLE_COUNT_EN
    logic [15:0]   RUN_CYCLES;
`endif

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] park_m;
    int           exp_q[$];

    always #5 CLK = ~CLK;

    sweep_ctrl #(.WIDTH(W), .NW(NW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_LO    (CMD_LO),
        .CMD_HI    (CMD_HI),
        .CMD_START (CMD_START),
        .CMD_UP    (CMD_UP),
        .CMD_N     (CMD_N),
        .ABORT     (ABORT),
        .COUNT     (COUNT),
        .LOAD      (LOAD),
        .DATA      (DATA),
        .COUNT_UP  (COUNT_UP),
        .BUSY      (BUSY),
        .DONE      (DONE),
`ifdef SWEEP_CTRL_CYCLE_COUNT_EN
        .RUN_CYCLES(RUN_CYCLES),
`endif
        .ERR       (ERR)
    );

    // The downstream 6-bit up/down counter.
    always @(posedge CLK) begin
        if (RESET)         COUNT <= '0;
        else if (LOAD)     COUNT <= DATA;
        else if (COUNT_UP) COUNT <= COUNT + 6'd1;
        else               COUNT <= COUNT - 6'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counter values seen from the first RUN cycle to the final frozen bound.
    function automatic void build_seq(input int lo, input int hi, input int st,
                                      input int up, input int n);
        int pos, dir, hits;
        exp_q.delete();
        pos  = st;
        dir  = up;
        hits = 0;
        exp_q.push_back(pos);
        while (hits < n) begin
            pos = (dir != 0) ? pos + 1 : pos - 1;
            exp_q.push_back(pos);
            if (pos == hi || pos == lo) begin
                hits++;
                dir = (dir != 0) ? 0 : 1;
            end
        end
    endfunction

    task automatic run_cmd(input int lo, input int hi, input int st, input int up,
                           input int n, input int abort_at, input int noise,
                           input string tag);
        bit valid_m;
        valid_m = (lo < st) && (st < hi) && (hi - lo >= 2) && (n >= 1);
        check({tag, "_ready"}, CMD_READY, 1);
        CMD_LO    = W'(lo);
        CMD_HI    = W'(hi);
        CMD_START = W'(st);
        CMD_UP    = up[0];
        CMD_N     = NW'(n);
        CMD_VALID = 1'b1;
        ABORT     = (noise != 0);
        step();
        CMD_VALID = 1'b0;
        if (!valid_m) begin
            ABORT = 1'b0;
            check({tag, "_err"}, ERR, 1);
            check({tag, "_err_busy"}, BUSY, 0);
            check({tag, "_err_count"}, COUNT, park_m);
            step();
            check({tag, "_err_clear"}, ERR, 0);
            check({tag, "_err_hold"}, COUNT, park_m);
            check({tag, "_err_ready"}, CMD_READY, 1);
        end else begin
            build_seq(lo, hi, st, up, n);
            check({tag, "_prime_busy"}, BUSY, 1);
            check({tag, "_prime_ready"}, CMD_READY, 0);
            check({tag, "_prime_count"}, COUNT, park_m);
            step();
            ABORT = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                check({tag, "_count"}, COUNT, exp_q[k]);
                if (k == exp_q.size() - 1) begin
                    check({tag, "_end_busy"}, BUSY, 0);
                    check({tag, "_done"}, DONE, 1);
                    park_m = W'(exp_q[k]);
                end else begin
                    check({tag, "_busy"}, BUSY, 1);
                    check({tag, "_nodone"}, DONE, 0);
                    if (k == abort_at) begin
                        ABORT = 1'b1;
                        step();
                        ABORT = 1'b0;
                        check({tag, "_abort_count"}, COUNT, exp_q[k+1]);
                        check({tag, "_abort_busy"}, BUSY, 0);
                        check({tag, "_abort_nodone"}, DONE, 0);
                        park_m = W'(exp_q[k+1]);
                        break;
                    end
                    step();
                end
            end
            step();
            check({tag, "_frozen"}, COUNT, park_m);
            check({tag, "_done_clear"}, DONE, 0);
            check({tag, "_idle_ready"}, CMD_READY, 1);
        end
    endtask

    typedef struct {
        int    lo, hi, st, up, n, abort_at, noise, fin;
        string name;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{10, 20, 15, 1, 3,  -1, 0, 20, "tri_up_n3"};
        tbl[1]  = '{10, 20, 12, 0, 1,  -1, 1, 10, "down_n1_abort_ignored"};
        tbl[2]  = '{10, 20, 10, 1, 2,  -1, 0, 10, "bad_start_eq_lo"};
        tbl[3]  = '{30, 31, 30, 1, 2,  -1, 0, 10, "bad_narrow"};
        tbl[4]  = '{10, 20, 15, 1, 0,  -1, 0, 10, "bad_n0"};
        tbl[5]  = '{10, 20, 20, 0, 1,  -1, 0, 10, "bad_start_eq_hi"};
        tbl[6]  = '{10, 20, 15, 1, 4,   2, 0, 18, "abort_at_17"};
        tbl[7]  = '{0,  63, 1,  0, 1,  -1, 0, 0,  "low_edge"};
        tbl[8]  = '{0,  2,  1,  1, 2,  -1, 0, 0,  "narrow_ok"};
        tbl[9]  = '{61, 63, 62, 1, 15, -1, 0, 63, "top_edge_n15"};
        tbl[10] = '{10, 20, 15, 1, 2,  14, 0, 10, "abort_beats_finish"};

        RESET = 1'b1; CMD_VALID = 1'b0; ABORT = 1'b0; CMD_UP = 1'b0;
        CMD_LO = '0; CMD_HI = '0; CMD_START = '0; CMD_N = '0;
        park_m = '0;
        step();
        step();
        check("rst_load", LOAD, 1);
        check("rst_data", DATA, 0);
        check("rst_count_up", COUNT_UP, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_ready", CMD_READY, 1);
        RESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_count0", COUNT, 0);
            check("idle_busy", BUSY, 0);
        end

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].lo, tbl[i].hi, tbl[i].st, tbl[i].up, tbl[i].n,
                    tbl[i].abort_at, tbl[i].noise, tbl[i].name);
            check({tbl[i].name, "_final"}, COUNT, tbl[i].fin);
`ifdef SWEEP_CTRL_CYCLE_COUNT_EN
            if (i == 0) check("run_cycles", RUN_CYCLES, 26);
`endif
        end

        // Reset in the middle of a sweep.
        CMD_LO = 6'd10; CMD_HI = 6'd20; CMD_START = 6'd15; CMD_UP = 1'b1; CMD_N = 4'd4;
        CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
        for (int c = 0; c < 20 && COUNT != 6'd13; c++) step();
        check("midrst_reach13", COUNT, 13);
        RESET = 1'b1;
        step();
        check("midrst_load", LOAD, 1);
        check("midrst_data", DATA, 0);
        check("midrst_count_up", COUNT_UP, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_err", ERR, 0);
        check("midrst_ready", CMD_READY, 1);
        check("midrst_count", COUNT, 0);
        RESET = 1'b0;
        step();
        check("midrst_frozen", COUNT, 0);
        park_m = '0;

        // Second command held pending while busy, accepted on return to IDLE.
        begin
            int c;
            CMD_LO = 6'd10; CMD_HI = 6'd20; CMD_START = 6'd15; CMD_UP = 1'b1; CMD_N = 4'd1;
            CMD_VALID = 1'b1;
            step();
            CMD_LO = 6'd5; CMD_HI = 6'd9; CMD_START = 6'd7; CMD_UP = 1'b0; CMD_N = 4'd1;
            c = 0;
            while (BUSY && c < 40) begin
                check("hold_ready", CMD_READY, 0);
                step();
                c++;
            end
            check("hold_timeout", (c < 40), 1);
            check("hold_a_done", DONE, 1);
            check("hold_a_count", COUNT, 20);
            check("hold_a_ready", CMD_READY, 1);
            step();
            CMD_VALID = 1'b0;
            check("hold_b_busy", BUSY, 1);
            check("hold_b_prime", COUNT, 20);
            step();
            check("hold_b_c0", COUNT, 7);
            step();
            check("hold_b_c1", COUNT, 6);
            step();
            check("hold_b_c2", COUNT, 5);
            check("hold_b_done", DONE, 1);
            step();
            check("hold_b_frozen", COUNT, 5);
            check("hold_b_done_clear", DONE, 0);
            park_m = 6'd5;
        end

        // Randomized commands, valid and otherwise.
        for (int r = 0; r < 40; r++) begin
            int lo, hi, st, up, n, ab, nz;
            if ($urandom_range(3) == 0) begin
                lo = $urandom_range(63);
                hi = $urandom_range(63);
                st = $urandom_range(63);
                n  = $urandom_range(3);
            end else begin
                lo = $urandom_range(58);
                hi = $urandom_range(63, lo + 2);
                st = $urandom_range(hi - 1, lo + 1);
                n  = $urandom_range(4, 1);
            end
            up = $urandom_range(1);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(60)) : -1;
            nz = $urandom_range(1);
            run_cmd(lo, hi, st, up, n, ab, nz, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
